// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader.
package operand_loader_pkg;

  localparam int NIB_W      = 4;
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage : operand_loader_pkg

// File: rtl/operand_loader_if.sv
// Nibble input bus, ALU acknowledge/flush and the operand outputs of the loader.
interface operand_loader_if;
  import operand_loader_pkg::*;

  logic             in_valid;
  logic [NIB_W-1:0] in_data;
  logic             in_ready;
  logic             alu_ack;
  logic             flush;
  logic             D;
  logic             A3, A2, A1, A0;
  logic             B3, B2, B1, B0;
  logic             busy;

  // Environment side: supplies nibbles, acknowledges and flushes.
  modport master (
    output in_valid, in_data, alu_ack, flush,
    input  in_ready, D, A3, A2, A1, A0, B3, B2, B1, B0, busy
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, alu_ack, flush,
    output in_ready, D, A3, A2, A1, A0, B3, B2, B1, B0, busy
  );
endinterface : operand_loader_if

// File: rtl/enable_hold_timer.sv
// Counts cycles the operand enable has been high; min_met flags that an
// acknowledge may now be honoured.
module enable_hold_timer
  import operand_loader_pkg::*;
#(
  parameter int unsigned HOLD_MIN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic min_met
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MIN);
  localparam logic [HOLD_CNT_W-1:0] HOLD_THR = HOLD_CNT_W'(HOLD_MIN - 1);

  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise saturate at HOLD_MIN.
  always_comb begin
    // NOTE: default assignment first so no path through always_comb infers a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q < HOLD_LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign min_met = (cnt_q >= HOLD_THR);

endmodule : enable_hold_timer

// File: rtl/operand_loader.sv
// Collects operand A then B from a shared nibble bus and holds them with the
// enable D high until the ALU acknowledges after the minimum hold time.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned HOLD_MIN   = 1,
  parameter bit          CLR_ON_REL = 1'b1
) (
  input logic              clk,
  input logic              rst,
  operand_loader_if.slave  bus
);

  state_e           state_q, state_d;
  logic [NIB_W-1:0] a_q, a_d;
  logic [NIB_W-1:0] b_q, b_d;
  logic             d_q, d_d;
  logic             busy_q, busy_d;
  logic             in_ready;
  logic             accept;
  logic             min_met;
  logic             tmr_clr;

  // in_ready decodes state only; HOLD refuses beats so upstream keeps its data.
  assign in_ready = (state_q != HOLD);
  assign accept   = bus.in_valid && in_ready;

  // Counter runs only while holding and restarts whenever HOLD is left.
  assign tmr_clr = (state_q != HOLD) || (state_d != HOLD);

  enable_hold_timer #(.HOLD_MIN(HOLD_MIN)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (state_q == HOLD),
    .min_met (min_met)
  );

  // Next-state, operand and registered-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (bus.flush) begin
      state_d = IDLE;
      if (CLR_ON_REL) begin
        a_d = '0;
        b_d = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_d     = bus.in_data;
            state_d = GOT_A;
          end
        end
        GOT_A: begin
          if (accept) begin
            b_d     = bus.in_data;
            state_d = HOLD;
          end
        end
        HOLD: begin
          // Early acks are dropped; only an ack with the minimum met releases.
          if (bus.alu_ack && min_met) begin
            state_d = IDLE;
            if (CLR_ON_REL) begin
              a_d = '0;
              b_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    d_d    = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  // Single state/output register bank; reset overrides every input.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset, so rst is tested inside the clocked block only.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.D        = d_q;
  assign bus.busy     = busy_q;
  assign {bus.A3, bus.A2, bus.A1, bus.A0} = a_q;
  assign {bus.B3, bus.B2, bus.B1, bus.B0} = b_q;

endmodule : operand_loader

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: three instances cover HOLD_MIN=1,
// HOLD_MIN=3 and CLR_ON_REL=0.
module tb_operand_loader;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  operand_loader_if if1 ();
  operand_loader_if if3 ();
  operand_loader_if if0 ();

  operand_loader #(.HOLD_MIN(1), .CLR_ON_REL(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  operand_loader #(.HOLD_MIN(3), .CLR_ON_REL(1'b1)) u3 (.clk(clk), .rst(rst), .bus(if3));
  operand_loader #(.HOLD_MIN(1), .CLR_ON_REL(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));

  wire [3:0] a1 = {if1.A3, if1.A2, if1.A1, if1.A0};
  wire [3:0] b1 = {if1.B3, if1.B2, if1.B1, if1.B0};
  wire [3:0] a3 = {if3.A3, if3.A2, if3.A1, if3.A0};
  wire [3:0] b3 = {if3.B3, if3.B2, if3.B1, if3.B0};
  wire [3:0] a0 = {if0.A3, if0.A2, if0.A1, if0.A0};
  wire [3:0] b0 = {if0.B3, if0.B2, if0.B1, if0.B0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if1.in_valid = 0; if1.in_data = 0; if1.alu_ack = 0; if1.flush = 0;
    if3.in_valid = 0; if3.in_data = 0; if3.alu_ack = 0; if3.flush = 0;
    if0.in_valid = 0; if0.in_data = 0; if0.alu_ack = 0; if0.flush = 0;
    tick(); tick();
    rst = 1'b0;
    check("rst_d",     8'(if1.D),        8'h0);
    check("rst_busy",  8'(if1.busy),     8'h0);
    check("rst_ready", 8'(if1.in_ready), 8'h1);
    check("rst_ab",    {a1, b1},         8'h00);

    // Reset in the middle of HOLD.
    if1.in_valid = 1; if1.in_data = 4'h7; tick();
    if1.in_data = 4'h2; tick();
    if1.in_valid = 0;
    check("t1_hold_d",     8'(if1.D),        8'h1);
    check("t1_hold_ready", 8'(if1.in_ready), 8'h0);
    check("t1_hold_ab",    {a1, b1},         8'h72);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("t1_rst_d",     8'(if1.D),        8'h0);
    check("t1_rst_busy",  8'(if1.busy),     8'h0);
    check("t1_rst_ready", 8'(if1.in_ready), 8'h1);
    check("t1_rst_ab",    {a1, b1},         8'h00);

    // Beats A then 5, HOLD_MIN=1, ack in first D cycle.
    if1.in_valid = 1; if1.in_data = 4'hA; tick();
    check("t2_gota_busy", 8'(if1.busy), 8'h1);
    check("t2_gota_d",    8'(if1.D),    8'h0);
    check("t2_gota_a",    8'(a1),       8'hA);
    if1.in_data = 4'h5; tick();
    if1.in_valid = 0; if1.alu_ack = 1;
    check("t2_d_high", 8'(if1.D),  8'h1);
    check("t2_ab",     {a1, b1},   8'hA5);
    tick();
    if1.alu_ack = 0;
    check("t2_d_fall", 8'(if1.D),    8'h0);
    check("t2_idle",   8'(if1.busy), 8'h0);
    check("t2_clr",    {a1, b1},     8'h00);

    // in_valid with F during HOLD is stalled, then taken as the next A.
    if1.in_valid = 1; if1.in_data = 4'h1; tick();
    if1.in_data = 4'h2; tick();
    if1.in_data = 4'hF;
    check("t4_ready0", 8'(if1.in_ready), 8'h0);
    tick();
    check("t4_stall_d",  8'(if1.D), 8'h1);
    check("t4_stall_ab", {a1, b1},  8'h12);
    if1.alu_ack = 1; tick();
    if1.alu_ack = 0;
    check("t4_rel_d",     8'(if1.D),        8'h0);
    check("t4_rel_ready", 8'(if1.in_ready), 8'h1);
    tick();
    if1.in_valid = 0;
    check("t4_newa",      8'(a1),        8'hF);
    check("t4_newa_busy", 8'(if1.busy),  8'h1);

    // Flush from GOT_A; a same-cycle beat is dropped and the next beat is A.
    if1.flush = 1; tick(); if1.flush = 0;
    check("t5_flush0_busy", 8'(if1.busy), 8'h0);
    if1.in_valid = 1; if1.in_data = 4'h3; tick();
    check("t5_a3", 8'(a1), 8'h3);
    if1.flush = 1; if1.in_data = 4'h6; tick();
    if1.flush = 0;
    check("t5_flush_busy",  8'(if1.busy),     8'h0);
    check("t5_flush_d",     8'(if1.D),        8'h0);
    check("t5_flush_ready", 8'(if1.in_ready), 8'h1);
    if1.in_data = 4'h9; tick();
    check("t5_a9",    8'(a1),      8'h9);
    check("t5_a9_d",  8'(if1.D),   8'h0);
    if1.in_data = 4'h4; tick();
    if1.in_valid = 0;
    check("t5_hold_d",  8'(if1.D), 8'h1);
    check("t5_hold_ab", {a1, b1},  8'h94);
    if1.alu_ack = 1; tick(); if1.alu_ack = 0;
    check("t5_rel_d", 8'(if1.D), 8'h0);

    // HOLD_MIN=3 with ack held from the first D cycle: D high 3 cycles.
    if3.in_valid = 1; if3.in_data = 4'h8; tick();
    if3.in_data = 4'h6; tick();
    if3.in_valid = 0; if3.alu_ack = 1;
    check("t3_d_c1", 8'(if3.D), 8'h1);
    tick();
    check("t3_d_c2", 8'(if3.D), 8'h1);
    check("t3_ab",   {a3, b3},  8'h86);
    tick();
    check("t3_d_c3", 8'(if3.D), 8'h1);
    tick();
    if3.alu_ack = 0;
    check("t3_d_fall", 8'(if3.D),    8'h0);
    check("t3_idle",   8'(if3.busy), 8'h0);

    // Single-cycle early ack is ignored and not remembered.
    if3.in_valid = 1; if3.in_data = 4'h3; tick();
    if3.in_data = 4'hC; tick();
    if3.in_valid = 0; if3.alu_ack = 1; tick();
    if3.alu_ack = 0;
    check("t3_early_d1", 8'(if3.D), 8'h1);
    tick(); tick(); tick();
    check("t3_early_d4", 8'(if3.D), 8'h1);
    check("t3_early_ab", {a3, b3},  8'h3C);
    if3.alu_ack = 1; tick(); if3.alu_ack = 0;
    check("t3_late_rel", 8'(if3.D), 8'h0);
    check("t3_late_clr", {a3, b3},  8'h00);

    // CLR_ON_REL=0 keeps the released pair.
    if0.in_valid = 1; if0.in_data = 4'hC; tick();
    if0.in_data = 4'h1; tick();
    if0.in_valid = 0; if0.alu_ack = 1;
    check("t6_d_high", 8'(if0.D), 8'h1);
    tick();
    if0.alu_ack = 0;
    check("t6_d_fall", 8'(if0.D),    8'h0);
    check("t6_busy",   8'(if0.busy), 8'h0);
    check("t6_keep",   {a0, b0},     8'hC1);
    tick();
    check("t6_keep2",  {a0, b0},     8'hC1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_operand_loader
